exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Instruction sequencer for the PIC16C5x core. Runs the Q1..Q4 phase ring, holds the IR and decodes it to the
//  per-phase execute state. That state drives register-file write control, the ALU and the PC.
//  Owns the two-stage fetch/execute overlap, skip/branch flushes (forced NOP) and SLEEP/wake.
// PARAMETERS
//  INSTR_WIDTH   12     instruction word width
//  NOP_WORD      12'h000  word forced into IR on flush and at reset
// PORTS
//  clk           in   1   core clock; one Q phase per cycle
//  rst           in   1   reset, synchronous, active-high
//  instrIn       in   12  program-memory word for PC; sampled in EX_Q4
//  aluZeroIn     in   1   ALU result==0, valid in EX_Q3/Q4 (DECFSZ/INCFSZ)
//  bitTestIn     in   1   value of addressed bit, valid in EX_Q3/Q4 (BTFSC/BTFSS)
//  wakeIn        in   1   wake request (WDT/pin), level
//  executeState  out  `EX_STATE_BITS  current execute state
//  irOut         out  12  instruction register
//  pcCommand     out  2   00 hold, 01 increment, 10 load (GOTO/CALL/RETLW), 11 reset-vector load
//  stackCommand  out  2   00 none, 01 push (CALL), 10 pop (RETLW)
//  flushOut      out  1   next IR load will be NOP_WORD
//  sleepOut      out  1   core in SLEEP
// BEHAVIOUR
//  Reset (rst=1 at posedge): executeState=EX_Q1, irOut=NOP_WORD, flushOut=1, pcCommand=11,
//   stackCommand=00, sleepOut=0. A mid-instruction reset aborts it: no Q4 state or write is issued.
//  Phase ring: EX_Q1 -> EX_Q2 -> EX_Q3 -> Q4 state -> EX_Q1, one state per clk; instruction cycle = 4 clk.
//  Q4 state is combinationally decoded from irOut: CLRF 0000_011f_ffff->EX_Q4_CLRF;
//   CLRW 0000_0100_0000->EX_Q4_CLRW; MOVWF 0000_001f_ffff->EX_Q4_MOVWF; BCF/BSF 010x->EX_Q4_BXF;
//   DECFSZ 0010_11, INCFSZ 0011_11->EX_Q4_FSZ; MOVF 0010_00->EX_Q4_MOVF;
//   IORLW/ANDLW/XORLW 1101/1110/1111->EX_Q4_ALUXLW; MOVLW 1100->EX_Q4_MOVLW;
//   BTFSC/BTFSS 011x->EX_Q4_BTFSX; GOTO 101x->EX_Q4_GOTO; CALL 1001->EX_Q4_CALL;
//   RETLW 1000->EX_Q4_RETLW; SLEEP 0000_0000_0011->EX_Q4_SLEEP;
//   SWAPF 0011_10->EX_Q4_NOSTAT; NOP/OPTION/TRIS/CLRWDT->EX_Q4_NOP;
//   remaining byte-oriented file ops (0000_10..0011_01)->EX_Q4_ELSE.
//  If flushOut=1 the executing word is NOP_WORD by construction, so no writes occur.
//  PC: pcCommand=01 in EX_Q1 of every non-sleep cycle. In Q4: GOTO->10; CALL->10 plus stackCommand=01;
//   RETLW->10 plus stackCommand=10. Otherwise 00. stackCommand is a one-cycle pulse in Q4 only.
//  IR load: on the EX_Q4->EX_Q1 edge, irOut<=flushNext ? NOP_WORD : instrIn.
//  flushNext is set in Q4 for GOTO/CALL/RETLW; FSZ with aluZeroIn=1; BTFSC with bitTestIn=0;
//   BTFSS with bitTestIn=1. flushOut mirrors the registered flag for the cycle it applies to.
//  SLEEP: after EX_Q4_SLEEP, state EX_SLEEP, sleepOut=1, pcCommand=00, IR frozen.
//   Wake: wakeIn sampled in EX_SLEEP -> next state EX_Q1, sleepOut=0, IR<=instrIn (no flush).
//   If wakeIn is already high in EX_Q4_SLEEP, the block still spends exactly one clk in EX_SLEEP.
//  Simultaneous: rst dominates wakeIn and all decode. A skip instruction that is itself flushed has no effect.
//  Back-to-back skips are legal: each flush applies only to the immediately following word.
// STRUCTURE
//  `EX_* state encodings, EX_STATE_BITS, PC/stack command codes and opcode masks go in the shared define.v.
//  Natural sub-module: exec_decode (pure combinational irOut -> Q4 state, branch/skip class).
//  Ring, IR, flush and sleep registers stay in the top module.
// TESTING
//  1. Reset 3 clk, release, feed MOVLW 0xC5A -> first cycle executes NOP (flush). Next cycle shows
//     EX_Q1,Q2,Q3,EX_Q4_MOVLW, with pcCommand=11 during reset and 01 at each Q1.
//  2. DECFSZ 0x2E7 with aluZeroIn=1 at Q4 -> flushOut=1; next instruction executes EX_Q4_NOP.
//     Repeat with aluZeroIn=0 -> next word executes normally.
//  3. CALL 0x912 -> Q4: pcCommand=10, stackCommand=01 for exactly 1 clk; following word flushed.
//     RETLW 0x8FF -> stackCommand=10, flush.
//  4. BTFSC/BTFSS x bitTestIn 0/1 (4 combos) -> flush only for BTFSC&0 and BTFSS&1.
//  5. SLEEP 0x003 -> EX_SLEEP, sleepOut=1, pcCommand=00 for 20 clk. Pulse wakeIn -> EX_Q1 next clk,
//     IR=instrIn.
//  6. Assert rst during EX_Q3 of CLRF 0x066 -> no EX_Q4_CLRF observed; all outputs at reset values next clk.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the PIC16C5x execute sequencer: execute-state encoding,
// PC/stack command codes and the fixed opcode words the decoder matches exactly.
package exec_sequencer_pkg;

    localparam int INSTR_WIDTH   = 12;
    localparam int EX_STATE_BITS = 5;

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD_DEFAULT = 12'h000;
    localparam logic [INSTR_WIDTH-1:0] OP_SLEEP         = 12'h003;
    localparam logic [INSTR_WIDTH-1:0] OP_CLRW          = 12'h040;

    typedef enum logic [EX_STATE_BITS-1:0] {
        EX_Q1        = 5'd0,
        EX_Q2        = 5'd1,
        EX_Q3        = 5'd2,
        EX_Q4_CLRF   = 5'd3,
        EX_Q4_CLRW   = 5'd4,
        EX_Q4_MOVWF  = 5'd5,
        EX_Q4_BXF    = 5'd6,
        EX_Q4_FSZ    = 5'd7,
        EX_Q4_MOVF   = 5'd8,
        EX_Q4_ALUXLW = 5'd9,
        EX_Q4_MOVLW  = 5'd10,
        EX_Q4_BTFSX  = 5'd11,
        EX_Q4_GOTO   = 5'd12,
        EX_Q4_CALL   = 5'd13,
        EX_Q4_RETLW  = 5'd14,
        EX_Q4_SLEEP  = 5'd15,
        EX_Q4_NOSTAT = 5'd16,
        EX_Q4_NOP    = 5'd17,
        EX_Q4_ELSE   = 5'd18,
        EX_SLEEP     = 5'd19
    } ex_state_t;

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_LOAD  = 2'b10;
    localparam logic [1:0] PC_RESET = 2'b11;

    localparam logic [1:0] STK_NONE = 2'b00;
    localparam logic [1:0] STK_PUSH = 2'b01;
    localparam logic [1:0] STK_POP  = 2'b10;

endpackage

// File: rtl/exec_decode.sv
// Pure combinational decode of the instruction register into the Q4 execute
// state plus the branch/skip class used to decide the next-word flush.
module exec_decode
    import exec_sequencer_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0]   ir,
    output logic [EX_STATE_BITS-1:0] q4_state,
    output logic                     is_branch,
    output logic                     is_fsz,
    output logic                     is_btfsc,
    output logic                     is_btfss
);

    ex_state_t decoded;

    always_comb begin
        decoded   = EX_Q4_NOP;
        is_branch = 1'b0;
        is_fsz    = 1'b0;
        is_btfsc  = 1'b0;
        is_btfss  = 1'b0;
        case (ir[11:10])
            2'b00: begin
                // Byte-oriented group; the 0000_00 and 0000_01 rows hold the
                // fixed-word and MOVWF/CLRF/CLRW encodings.
                case (ir[9:6])
                    4'b0000: begin
                        if (ir[5])
                            decoded = EX_Q4_MOVWF;
                        else if (ir == OP_SLEEP)
                            decoded = EX_Q4_SLEEP;
                        else
                            decoded = EX_Q4_NOP;
                    end
                    4'b0001: begin
                        if (ir[5])
                            decoded = EX_Q4_CLRF;
                        else if (ir == OP_CLRW)
                            decoded = EX_Q4_CLRW;
                        else
                            decoded = EX_Q4_NOP;
                    end
                    4'b1000: decoded = EX_Q4_MOVF;
                    4'b1011, 4'b1111: begin
                        decoded = EX_Q4_FSZ;
                        is_fsz  = 1'b1;
                    end
                    4'b1110: decoded = EX_Q4_NOSTAT;
                    default: decoded = EX_Q4_ELSE;
                endcase
            end
            2'b01: begin
                if (ir[9]) begin
                    decoded  = EX_Q4_BTFSX;
                    is_btfsc = ~ir[8];
                    is_btfss = ir[8];
                end else begin
                    decoded = EX_Q4_BXF;
                end
            end
            2'b10: begin
                is_branch = 1'b1;
                if (ir[9])
                    decoded = EX_Q4_GOTO;
                else if (ir[8])
                    decoded = EX_Q4_CALL;
                else
                    decoded = EX_Q4_RETLW;
            end
            default: begin
                if (ir[9:8] == 2'b00)
                    decoded = EX_Q4_MOVLW;
                else
                    decoded = EX_Q4_ALUXLW;
            end
        endcase
    end

    assign q4_state = decoded;

endmodule

// File: rtl/exec_sequencer.sv
// PIC16C5x instruction sequencer: Q1..Q4 phase ring, instruction register,
// fetch/execute overlap with skip/branch flush, and SLEEP/wake handling.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instrIn,
    input  logic                     aluZeroIn,
    input  logic                     bitTestIn,
    input  logic                     wakeIn,
    output logic [EX_STATE_BITS-1:0] executeState,
    output logic [INSTR_WIDTH-1:0]   irOut,
    output logic [1:0]               pcCommand,
    output logic [1:0]               stackCommand,
    output logic                     flushOut,
    output logic                     sleepOut
);

    ex_state_t                state;
    ex_state_t                state_next;
    logic [INSTR_WIDTH-1:0]   ir;
    logic                     flush;
    logic                     in_reset;
    logic                     ir_load;
    logic                     flush_next;
    logic [EX_STATE_BITS-1:0] q4_bits;
    logic                     is_branch;
    logic                     is_fsz;
    logic                     is_btfsc;
    logic                     is_btfss;

    exec_decode u_decode (
        .ir        (ir),
        .q4_state  (q4_bits),
        .is_branch (is_branch),
        .is_fsz    (is_fsz),
        .is_btfsc  (is_btfsc),
        .is_btfss  (is_btfss)
    );

    // in_reset marks the Q1 immediately following reset so the PC takes the
    // reset vector there instead of incrementing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EX_Q1;
            ir       <= NOP_WORD;
            flush    <= 1'b1;
            in_reset <= 1'b1;
        end else begin
            state    <= state_next;
            in_reset <= 1'b0;
            if (ir_load) begin
                ir    <= flush_next ? NOP_WORD : instrIn;
                flush <= flush_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        flush_next = 1'b0;
        case (state)
            EX_Q1:       state_next = EX_Q2;
            EX_Q2:       state_next = EX_Q3;
            EX_Q3:       state_next = ex_state_t'(q4_bits);
            EX_Q4_SLEEP: state_next = EX_SLEEP;
            EX_SLEEP: begin
                if (wakeIn) begin
                    state_next = EX_Q1;
                    ir_load    = 1'b1;
                end
            end
            default: begin
                // Every other Q4 state closes the instruction cycle and fetches.
                state_next = EX_Q1;
                ir_load    = 1'b1;
                flush_next = is_branch
                           | (is_fsz & aluZeroIn)
                           | (is_btfsc & ~bitTestIn)
                           | (is_btfss & bitTestIn);
            end
        endcase
    end

    always_comb begin
        pcCommand    = PC_HOLD;
        stackCommand = STK_NONE;
        if (in_reset) begin
            pcCommand = PC_RESET;
        end else begin
            case (state)
                EX_Q1:      pcCommand = PC_INC;
                EX_Q4_GOTO: pcCommand = PC_LOAD;
                EX_Q4_CALL: begin
                    pcCommand    = PC_LOAD;
                    stackCommand = STK_PUSH;
                end
                EX_Q4_RETLW: begin
                    pcCommand    = PC_LOAD;
                    stackCommand = STK_POP;
                end
                default: pcCommand = PC_HOLD;
            endcase
        end
    end

    assign executeState = state;
    assign irOut        = ir;
    assign flushOut     = flush;
    assign sleepOut     = (state == EX_SLEEP);

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: reset, opcode vector table, skip/branch,
// sleep/wake and mid-instruction reset, then random words against an instruction-level model.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] instrIn;
    logic        aluZeroIn;
    logic        bitTestIn;
    logic        wakeIn;
    logic [4:0]  executeState;
    logic [11:0] irOut;
    logic [1:0]  pcCommand;
    logic [1:0]  stackCommand;
    logic        flushOut;
    logic        sleepOut;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instruction-level model: the word executing next cycle, whether it is a forced NOP,
    // and the PC command expected at that cycle's Q1.
    logic [11:0] model_ir;
    logic        model_flush;
    logic [1:0]  model_pc_q1;

    typedef struct {
        logic [11:0] mask;
        logic [11:0] match;
        ex_state_t   st;
    } pat_t;

    typedef struct {
        logic [11:0] instr;
        logic        alu;
        logic        bitv;
        ex_state_t   exp_state;
        logic        exp_flush;
    } vec_t;

    pat_t pats[$];
    vec_t vecs[$];

    exec_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instrIn      (instrIn),
        .aluZeroIn    (aluZeroIn),
        .bitTestIn    (bitTestIn),
        .wakeIn       (wakeIn),
        .executeState (executeState),
        .irOut        (irOut),
        .pcCommand    (pcCommand),
        .stackCommand (stackCommand),
        .flushOut     (flushOut),
        .sleepOut     (sleepOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // First matching mask/value row gives the Q4 state of a word.
    function automatic ex_state_t classify(input logic [11:0] w);
        foreach (pats[i]) begin
            if ((w & pats[i].mask) == pats[i].match) return pats[i].st;
        end
        return EX_Q4_NOP;
    endfunction

    function automatic logic flushRule(input logic [11:0] w, input logic alu, input logic bitv);
        ex_state_t  c;
        logic [3:0] op;
        c  = classify(w);
        op = w[11:8];
        if (c == EX_Q4_GOTO || c == EX_Q4_CALL || c == EX_Q4_RETLW) return 1'b1;
        if (c == EX_Q4_FSZ) return alu;
        if (op == 4'h6) return !bitv;
        if (op == 4'h7) return bitv;
        return 1'b0;
    endfunction

    function automatic int expPc(input ex_state_t c);
        if (c == EX_Q4_GOTO || c == EX_Q4_CALL || c == EX_Q4_RETLW) return 2;
        return 0;
    endfunction

    function automatic int expStack(input ex_state_t c);
        if (c == EX_Q4_CALL) return 1;
        if (c == EX_Q4_RETLW) return 2;
        return 0;
    endfunction

    // Runs one full instruction cycle starting at its Q1; next_word is offered on instrIn.
    task automatic applyStimulus(input logic [11:0] next_word, input logic alu,
                                 input logic bitv, output logic [4:0] q4_seen);
        ex_state_t exp_q4;
        logic      fl;
        instrIn   = next_word;
        aluZeroIn = alu;
        bitTestIn = bitv;
        checkOutput("q1_state", executeState, EX_Q1);
        checkOutput("q1_pc", pcCommand, model_pc_q1);
        checkOutput("q1_stack", stackCommand, 0);
        checkOutput("q1_ir", irOut, model_ir);
        checkOutput("q1_flush", flushOut, model_flush);
        checkOutput("q1_sleep", sleepOut, 0);
        step();
        checkOutput("q2_state", executeState, EX_Q2);
        checkOutput("q2_pc", pcCommand, 0);
        step();
        checkOutput("q3_state", executeState, EX_Q3);
        checkOutput("q3_stack", stackCommand, 0);
        step();
        exp_q4 = classify(model_ir);
        checkOutput("q4_state", executeState, exp_q4);
        checkOutput("q4_pc", pcCommand, expPc(exp_q4));
        checkOutput("q4_stack", stackCommand, expStack(exp_q4));
        q4_seen     = executeState;
        fl          = flushRule(model_ir, alu, bitv);
        model_ir    = fl ? 12'h000 : next_word;
        model_flush = fl;
        model_pc_q1 = 2'b01;
        step();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, executeState, EX_Q1);
        checkOutput({tag, "_ir"}, irOut, 12'h000);
        checkOutput({tag, "_flush"}, flushOut, 1);
        checkOutput({tag, "_pc"}, pcCommand, 2'b11);
        checkOutput({tag, "_stack"}, stackCommand, 0);
        checkOutput({tag, "_sleep"}, sleepOut, 0);
    endtask

    task automatic modelReset();
        model_ir    = 12'h000;
        model_flush = 1'b1;
        model_pc_q1 = 2'b11;
    endtask

    initial begin
        logic [4:0]  seen;
        logic [11:0] w;

        pats.push_back('{12'hFFF, 12'h003, EX_Q4_SLEEP});
        pats.push_back('{12'hFFF, 12'h040, EX_Q4_CLRW});
        pats.push_back('{12'hFE0, 12'h060, EX_Q4_CLRF});
        pats.push_back('{12'hFE0, 12'h020, EX_Q4_MOVWF});
        pats.push_back('{12'hFC0, 12'h000, EX_Q4_NOP});
        pats.push_back('{12'hFC0, 12'h040, EX_Q4_NOP});
        pats.push_back('{12'hFC0, 12'h2C0, EX_Q4_FSZ});
        pats.push_back('{12'hFC0, 12'h3C0, EX_Q4_FSZ});
        pats.push_back('{12'hFC0, 12'h200, EX_Q4_MOVF});
        pats.push_back('{12'hFC0, 12'h380, EX_Q4_NOSTAT});
        pats.push_back('{12'hC00, 12'h000, EX_Q4_ELSE});
        pats.push_back('{12'hE00, 12'h400, EX_Q4_BXF});
        pats.push_back('{12'hE00, 12'h600, EX_Q4_BTFSX});
        pats.push_back('{12'hF00, 12'h800, EX_Q4_RETLW});
        pats.push_back('{12'hF00, 12'h900, EX_Q4_CALL});
        pats.push_back('{12'hE00, 12'hA00, EX_Q4_GOTO});
        pats.push_back('{12'hF00, 12'hC00, EX_Q4_MOVLW});
        pats.push_back('{12'hC00, 12'hC00, EX_Q4_ALUXLW});

        vecs.push_back('{12'hC5A, 1'b0, 1'b0, EX_Q4_MOVLW,  1'b0});
        vecs.push_back('{12'h2E7, 1'b1, 1'b0, EX_Q4_FSZ,    1'b1});
        vecs.push_back('{12'h2E7, 1'b0, 1'b0, EX_Q4_FSZ,    1'b0});
        vecs.push_back('{12'h3C4, 1'b1, 1'b1, EX_Q4_FSZ,    1'b1});
        vecs.push_back('{12'h912, 1'b0, 1'b0, EX_Q4_CALL,   1'b1});
        vecs.push_back('{12'h8FF, 1'b0, 1'b0, EX_Q4_RETLW,  1'b1});
        vecs.push_back('{12'hA05, 1'b0, 1'b0, EX_Q4_GOTO,   1'b1});
        vecs.push_back('{12'h6A3, 1'b0, 1'b0, EX_Q4_BTFSX,  1'b1});
        vecs.push_back('{12'h6A3, 1'b0, 1'b1, EX_Q4_BTFSX,  1'b0});
        vecs.push_back('{12'h7A3, 1'b0, 1'b0, EX_Q4_BTFSX,  1'b0});
        vecs.push_back('{12'h7A3, 1'b0, 1'b1, EX_Q4_BTFSX,  1'b1});
        vecs.push_back('{12'h066, 1'b0, 1'b0, EX_Q4_CLRF,   1'b0});
        vecs.push_back('{12'h040, 1'b0, 1'b0, EX_Q4_CLRW,   1'b0});
        vecs.push_back('{12'h025, 1'b0, 1'b0, EX_Q4_MOVWF,  1'b0});
        vecs.push_back('{12'h5A3, 1'b0, 1'b1, EX_Q4_BXF,    1'b0});
        vecs.push_back('{12'h4A3, 1'b0, 1'b0, EX_Q4_BXF,    1'b0});
        vecs.push_back('{12'h20F, 1'b1, 1'b0, EX_Q4_MOVF,   1'b0});
        vecs.push_back('{12'h38F, 1'b1, 1'b1, EX_Q4_NOSTAT, 1'b0});
        vecs.push_back('{12'h1C5, 1'b1, 1'b0, EX_Q4_ELSE,   1'b0});
        vecs.push_back('{12'hD0F, 1'b0, 1'b0, EX_Q4_ALUXLW, 1'b0});
        vecs.push_back('{12'hF0F, 1'b0, 1'b0, EX_Q4_ALUXLW, 1'b0});
        vecs.push_back('{12'h000, 1'b1, 1'b1, EX_Q4_NOP,    1'b0});
        vecs.push_back('{12'h004, 1'b1, 1'b0, EX_Q4_NOP,    1'b0});
        vecs.push_back('{12'h002, 1'b0, 1'b1, EX_Q4_NOP,    1'b0});

        rst       = 1'b1;
        instrIn   = 12'h000;
        aluZeroIn = 1'b0;
        bitTestIn = 1'b0;
        wakeIn    = 1'b0;

        // Reset held for three clocks, then MOVLW fetched behind the reset NOP.
        for (int i = 0; i < 3; i++) begin
            step();
            checkResetValues("reset");
        end
        rst = 1'b0;
        modelReset();
        applyStimulus(12'hC5A, 1'b0, 1'b0, seen);
        checkOutput("first_cycle_nop", seen, EX_Q4_NOP);
        applyStimulus(12'hC00, 1'b0, 1'b0, seen);
        checkOutput("movlw_q4", seen, EX_Q4_MOVLW);

        // Opcode vector table: load the word, execute it, check Q4 state and the following flush.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].instr, 1'b0, 1'b0, seen);
            applyStimulus(12'hC11, vecs[i].alu, vecs[i].bitv, seen);
            checkOutput($sformatf("vec%0d_state", i), seen, vecs[i].exp_state);
            checkOutput($sformatf("vec%0d_flush", i), flushOut, vecs[i].exp_flush);
            checkOutput($sformatf("vec%0d_ir", i), irOut, vecs[i].exp_flush ? 12'h000 : 12'hC11);
        end

        // Back-to-back skips: the second DECFSZ is flushed and must not skip.
        applyStimulus(12'h2E7, 1'b0, 1'b0, seen);
        applyStimulus(12'h2E7, 1'b1, 1'b0, seen);
        applyStimulus(12'hC33, 1'b1, 1'b0, seen);
        checkOutput("flushed_skip_q4", seen, EX_Q4_NOP);
        checkOutput("flushed_skip_ir", irOut, 12'hC33);
        checkOutput("flushed_skip_flush", flushOut, 0);

        // SLEEP held for 20 clocks, then a wake pulse.
        applyStimulus(12'h003, 1'b0, 1'b0, seen);
        instrIn = 12'hC77;
        step();
        step();
        step();
        checkOutput("sleep_q4", executeState, EX_Q4_SLEEP);
        checkOutput("sleep_q4_pc", pcCommand, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            checkOutput("sleep_state", executeState, EX_SLEEP);
            checkOutput("sleep_out", sleepOut, 1);
            checkOutput("sleep_pc", pcCommand, 0);
            checkOutput("sleep_ir", irOut, 12'h003);
            step();
        end
        wakeIn = 1'b1;
        step();
        wakeIn = 1'b0;
        checkOutput("wake_state", executeState, EX_Q1);
        checkOutput("wake_sleep", sleepOut, 0);
        checkOutput("wake_ir", irOut, 12'hC77);
        checkOutput("wake_flush", flushOut, 0);
        model_ir    = 12'hC77;
        model_flush = 1'b0;
        model_pc_q1 = 2'b01;
        applyStimulus(12'hC00, 1'b0, 1'b0, seen);
        checkOutput("wake_exec", seen, EX_Q4_MOVLW);

        // Wake already high at EX_Q4_SLEEP still costs exactly one EX_SLEEP clock.
        applyStimulus(12'h003, 1'b0, 1'b0, seen);
        step();
        step();
        wakeIn  = 1'b1;
        instrIn = 12'hC88;
        step();
        checkOutput("early_wake_q4", executeState, EX_Q4_SLEEP);
        step();
        checkOutput("early_wake_sleep", executeState, EX_SLEEP);
        step();
        wakeIn = 1'b0;
        checkOutput("early_wake_q1", executeState, EX_Q1);
        checkOutput("early_wake_ir", irOut, 12'hC88);
        model_ir    = 12'hC88;
        model_flush = 1'b0;
        model_pc_q1 = 2'b01;
        applyStimulus(12'hC00, 1'b0, 1'b0, seen);

        // Reset dominates a simultaneous wake request.
        applyStimulus(12'h003, 1'b0, 1'b0, seen);
        step();
        step();
        step();
        step();
        checkOutput("rst_wake_sleep", executeState, EX_SLEEP);
        rst    = 1'b1;
        wakeIn = 1'b1;
        step();
        rst    = 1'b0;
        wakeIn = 1'b0;
        checkResetValues("rst_wake");
        modelReset();
        applyStimulus(12'h066, 1'b0, 1'b0, seen);

        // Reset during Q3 of CLRF aborts it before any Q4.
        step();
        step();
        checkOutput("clrf_q3", executeState, EX_Q3);
        checkOutput("clrf_ir", irOut, 12'h066);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkResetValues("clrf_abort");
        modelReset();

        // Random words against the instruction-level model.
        for (int n = 0; n < 300; n++) begin
            w = 12'($urandom_range(0, 4095));
            if (w == 12'h003) w = 12'h000;
            applyStimulus(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
